spi_slave_transceiver: RTL and testbench
========================================

// Module: spi_slave_transceiver
// PURPOSE
//   Full-duplex SPI responder, the slave end of the link driven by our SPI master.
//   Oversamples the external sck/cs/mosi pins in the system clock domain.
//   Supports all four ckp/cph modes and back-to-back frames while cs stays low.
//   Parallel side: one-entry TX holding buffer (valid/ready) and a one-cycle rx_valid strobe.
// PARAMETERS
//   DATA_LENGTH  8     bits per frame; legal range 2..32
//   SYNC_STAGES  2     flops in each pin synchronizer; minimum 2
//   TX_FILL      '1    word shifted out when no TX word is buffered at frame start
// PORTS
//   clk       in   1            system clock; must be >= 8x the sck frequency
//   reset     in   1            synchronous, active-high
//   sck       in   1            SPI clock from master (asynchronous)
//   cs        in   1            chip select, active-low (asynchronous)
//   mosi      in   1            serial data from master
//   miso      out  1            serial data to master
//   ckp       in   1            clock polarity (sck idle level)
//   cph       in   1            clock phase: 0 = sample on leading edge, 1 = sample on trailing edge
//   tx_data   in   DATA_LENGTH  word to send in a following frame
//   tx_valid  in   1            tx_data valid
//   tx_ready  out  1            TX buffer empty; a write is accepted when tx_valid && tx_ready
//   rx_data   out  DATA_LENGTH  last complete received word; held until the next one completes
//   rx_valid  out  1            one-clk pulse when rx_data updates
//   busy      out  1            high while a frame is in progress (state SHIFT)
// BEHAVIOUR
//   Reset values: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0; TX buffer emptied; state=IDLE.
//   Sync: sck, cs and mosi each pass through SYNC_STAGES flops. Edges are detected against the
//     previous synced value, so a pin edge acts SYNC_STAGES+1 clk cycles later.
//   Edge roles: sample edge = rising when ckp==cph, falling otherwise. Shift edge is the opposite edge.
//   ckp and cph are latched on the cs falling edge and ignored for the rest of the frame.
//   IDLE: miso=0, busy=0. Synced cs falling edge enters SHIFT:
//     - load tx_shift from the TX buffer and mark it empty; if the buffer is empty, load TX_FILL
//     - bit_cnt=0; if cph=0, drive the first bit on miso in the same cycle
//   SHIFT: busy=1.
//     - sample edge: shift mosi into rx_shift; bit_cnt++
//     - shift edge: drive the next tx bit on miso; when cph=1 the first shift edge drives the first bit
//     - word end: on the sample edge where bit_cnt reaches DATA_LENGTH, next cycle
//       rx_data <= rx_shift, rx_valid=1 for 1 clk, bit_cnt=0, and tx_shift reloads from
//       buffer/TX_FILL. Back-to-back frames run with no gap while cs stays low.
//   cs rising mid-word: abort; discard the partial rx word, no rx_valid; go to IDLE and drive miso=0.
//     The tx word already loaded is lost, not re-queued.
//   cs rising exactly at a word end: rx_valid still fires for the completed word.
//   TX buffer: tx_ready=0 while full. If a write and a frame-start consume occur in the same cycle,
//     the old word is consumed and the new word is held for the next frame.
//   rx overrun: rx_data is simply overwritten; no flag.
//   Reset mid-frame: outputs go to their reset values. If cs is still low after reset, stay in IDLE
//     until cs goes high and then falls again.
//   Sck glitches with cs high are ignored. Edges of sck while in IDLE are ignored.
// CONFIGURATION
//   SPI_SLAVE_LSB_FIRST_EN defined: tx and rx shift LSB first (bit 0 first on the wire,
//     first received bit lands in rx_data[0]).
//   Not defined (default): MSB first, matching our master.
// TESTING
//   Mode 0, buffer tx_data=8'h06, master sends 8'h08 -> rx_data=8'h08, rx_valid 1 clk, master reads 8'h06.
//   Mode 3 (ckp=1,cph=1), tx 8'h03, master sends 8'h02 -> rx_data=8'h02, master reads 8'h03.
//   Modes 1 and 2, tx 8'hA5, master sends 8'h5A -> rx_data=8'h5A, master reads 8'hA5 in each mode.
//   cs low for 16 bits, tx 8'h11 then 8'h22, master sends 8'hC3,8'h3C -> two rx_valid
//     pulses (8'hC3, 8'h3C); master reads 8'h11, 8'h22; tx_ready rises after each load.
//   Empty buffer, then cs raised after 5 bits -> master reads 8'hFF prefix, no rx_valid, busy=0, miso=0.
//   reset asserted at bit 4 with cs held low -> no activity until cs toggles; next frame with tx 8'h06 exchanges cleanly.
//   With SPI_SLAVE_LSB_FIRST_EN: wire bits 0,0,0,1,0,0,0,0 (first to last) -> rx_data=8'h08.

Source files
------------

// File: rtl/spi_slave_transceiver.sv
// SPI slave transceiver: oversampled pins, all four ckp/cph modes, back-to-back frames, one-entry TX buffer.
// Pin edges act SYNC_STAGES+1 clk later; define SPI_SLAVE_LSB_FIRST_EN to shift LSB first (default MSB first).
module spi_slave_transceiver #(
   parameter int unsigned            DATA_LENGTH = 8,
   parameter int unsigned            SYNC_STAGES = 2,
   parameter logic [DATA_LENGTH-1:0] TX_FILL     = '1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sck,
   input  logic                   cs,
   input  logic                   mosi,
   output logic                   miso,
   input  logic                   ckp,
   input  logic                   cph,
   input  logic [DATA_LENGTH-1:0] tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic [DATA_LENGTH-1:0] rx_data,
   output logic                   rx_valid,
   output logic                   busy
);
   localparam int unsigned   CW       = $clog2(DATA_LENGTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_LENGTH - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sck_prev_q, cs_prev_q;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_rise, cs_fall;
   logic                   sample_edge, shift_edge;

   logic                   ckp_q, ckp_d, cph_q, cph_d;
   logic [DATA_LENGTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_LENGTH-1:0] tx_rot, next_word, next_rot;
   logic [DATA_LENGTH-2:0] rx_shift_q, rx_shift_d, rx_shift_next;
   logic [DATA_LENGTH-1:0] rx_full;
   logic [DATA_LENGTH-1:0] rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   miso_q, miso_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [DATA_LENGTH-1:0] buf_q, buf_d;
   logic                   buf_full_q, buf_full_d;
   logic                   consume, tx_accept;

   // cs chain resets low so a cs held low across reset never looks like a fresh falling edge
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sck_prev_q  <= sck_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sck_s       = sck_sync_q[SYNC_STAGES-1];
   assign cs_s        = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise    = sck_s & ~sck_prev_q;
   assign sck_fall    = ~sck_s & sck_prev_q;
   assign cs_rise     = cs_s & ~cs_prev_q;
   assign cs_fall     = ~cs_s & cs_prev_q;
   assign sample_edge = (ckp_q == cph_q) ? sck_rise : sck_fall;
   assign shift_edge  = (ckp_q == cph_q) ? sck_fall : sck_rise;

   assign next_word = buf_full_q ? buf_q : TX_FILL;

`ifdef SPI_SLAVE_LSB_FIRST_EN
   localparam int unsigned TX_FIRST = 0;
   assign tx_rot        = {tx_shift_q[0], tx_shift_q[DATA_LENGTH-1:1]};
   assign next_rot      = {next_word[0], next_word[DATA_LENGTH-1:1]};
   assign rx_full       = {mosi_s, rx_shift_q};
   assign rx_shift_next = rx_full[DATA_LENGTH-1:1];
`else
   localparam int unsigned TX_FIRST = DATA_LENGTH - 1;
   assign tx_rot        = {tx_shift_q[DATA_LENGTH-2:0], tx_shift_q[DATA_LENGTH-1]};
   assign next_rot      = {next_word[DATA_LENGTH-2:0], next_word[DATA_LENGTH-1]};
   assign rx_full       = {rx_shift_q, mosi_s};
   assign rx_shift_next = rx_full[DATA_LENGTH-2:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ckp_q      <= 1'b0;
         cph_q      <= 1'b0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b0;
         bit_cnt_q  <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ckp_q      <= ckp_d;
         cph_q      <= cph_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_q     <= miso_d;
         bit_cnt_q  <= bit_cnt_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall) state_d = SHIFT;
         SHIFT:   if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ckp_d      = ckp_q;
      cph_d      = cph_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      miso_d     = miso_q;
      bit_cnt_d  = bit_cnt_q;
      consume    = 1'b0;
      case (state_q)
         IDLE: begin
            miso_d    = 1'b0;
            bit_cnt_d = '0;
            if (cs_fall) begin
               ckp_d   = ckp;
               cph_d   = cph;
               consume = 1'b1;
               if (!cph) begin
                  miso_d     = next_word[TX_FIRST];
                  tx_shift_d = next_rot;
               end else begin
                  tx_shift_d = next_word;
               end
            end
         end
         SHIFT: begin
            if (shift_edge) begin
               miso_d     = tx_shift_q[TX_FIRST];
               tx_shift_d = tx_rot;
            end
            if (sample_edge) begin
               rx_shift_d = rx_shift_next;
               bit_cnt_d  = bit_cnt_q + CW'(1);
               // Word end: publish, then reload so the next shift edge starts the following word
               if (bit_cnt_q == LAST_BIT) begin
                  rx_data_d  = rx_full;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
                  if (!cs_rise) begin
                     consume    = 1'b1;
                     tx_shift_d = next_word;
                  end
               end
            end
            if (cs_rise) begin
               miso_d    = 1'b0;
               bit_cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   assign tx_accept = tx_valid & ~buf_full_q;

   always_comb begin
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      if (consume) buf_full_d = 1'b0;
      if (tx_accept) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end
   end

   always_comb begin
      busy     = (state_q == SHIFT);
      miso     = miso_q;
      tx_ready = ~buf_full_q;
      rx_data  = rx_data_q;
      rx_valid = rx_valid_q;
   end

endmodule

// File: tb/tb_spi_slave_transceiver.sv
// Scoreboard bench for spi_slave_transceiver: a bit-level SPI master drives frames, monitors check rx words and miso words.
module tb_spi_slave_transceiver;
   localparam int HALF = 80;

   logic       clk, reset, sck, cs, mosi, miso, ckp, cph;
   logic [7:0] tx_data, rx_data;
   logic       tx_valid, tx_ready, rx_valid, busy;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_rx_q[$];
   logic [7:0] exp_miso_q[$];
   logic [7:0] mr_word;
   logic [15:0] rd_acc;
   event       mr_ev;

   spi_slave_transceiver dut (
      .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
      .ckp(ckp), .cph(cph), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int bit_pos(input int i);
      int j;
      j = i % 8;
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return j;
`else
      return 7 - j;
`endif
   endfunction

   function automatic logic wire_bit(input logic [15:0] s, input int i);
      logic [7:0] w;
      w = (i < 8) ? s[15:8] : s[7:0];
      return w[bit_pos(i)];
   endfunction

   // Scoreboard monitors
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         if (exp_rx_q.size() == 0) check("rx_valid_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
         else check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx_q.pop_front()});
      end
   end

   always @(mr_ev) begin
      if (exp_miso_q.size() == 0) check("miso_word_unexpected", {24'h0, mr_word}, 32'hFFFF_FFFF);
      else check("miso_word", {24'h0, mr_word}, {24'h0, exp_miso_q.pop_front()});
   end

   task automatic master_frame(input logic p, input logic h, input logic [15:0] s,
                               input int nbits, input bit raise);
      logic [7:0] cur;
      logic       b;
      cur    = '0;
      rd_acc = '0;
      @(negedge clk);
      ckp = p;
      cph = h;
      sck = p;
      #(HALF);
      cs = 1'b0;
      if (!h) mosi = wire_bit(s, 0);
      #(HALF);
      for (int i = 0; i < nbits; i++) begin
         sck = ~p;
         if (h) mosi = wire_bit(s, i);
         else begin
            b = miso;
            cur[bit_pos(i)] = b;
            rd_acc = {rd_acc[14:0], b};
         end
         #(HALF);
         sck = p;
         if (h) begin
            b = miso;
            cur[bit_pos(i)] = b;
            rd_acc = {rd_acc[14:0], b};
         end else if (i + 1 < nbits) mosi = wire_bit(s, i + 1);
         #(HALF);
         if (i % 8 == 7) begin
            mr_word = cur;
            ->mr_ev;
            cur = '0;
         end
      end
      if (raise) begin
         cs   = 1'b1;
         mosi = 1'b0;
         #(4 * HALF);
      end
   endtask

   task automatic tx_write(input logic [7:0] v);
      int n;
      n = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("tx_ready_before_write", {31'h0, tx_ready}, 32'h1);
      tx_data  = v;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_ready_after_write", {31'h0, tx_ready}, 32'h0);
   endtask

   task automatic idle_checks(input string tag);
      check({tag, "_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_miso"}, {31'h0, miso}, 32'h0);
   endtask

   task automatic single(input logic p, input logic h, input logic [7:0] txw, input logic [7:0] rxw);
      tx_write(txw);
      exp_rx_q.push_back(rxw);
      exp_miso_q.push_back(txw);
      master_frame(p, h, {rxw, 8'h00}, 8, 1'b1);
      idle_checks("after_frame");
   endtask

   task automatic wait_tx_ready(input string name);
      int n;
      n = 0;
      while (tx_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'h0, tx_ready}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; ckp = 1'b0; cph = 1'b0;
      tx_data = '0; tx_valid = 1'b0; mr_word = '0; rd_acc = '0;
      repeat (4) @(negedge clk);
      idle_checks("reset");
      check("reset_tx_ready", {31'h0, tx_ready}, 32'h1);
      check("reset_rx_data", {24'h0, rx_data}, 32'h0);
      check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      single(1'b0, 1'b0, 8'h06, 8'h08);
      single(1'b1, 1'b1, 8'h03, 8'h02);
      single(1'b0, 1'b1, 8'hA5, 8'h5A);
      single(1'b1, 1'b0, 8'hA5, 8'h5A);

      // Back-to-back words with cs held low
      tx_write(8'h11);
      exp_rx_q.push_back(8'hC3);  exp_rx_q.push_back(8'h3C);
      exp_miso_q.push_back(8'h11); exp_miso_q.push_back(8'h22);
      fork
         master_frame(1'b0, 1'b0, 16'hC33C, 16, 1'b1);
         begin
            wait_tx_ready("tx_ready_after_first_load");
            check("busy_mid_frame", {31'h0, busy}, 32'h1);
            tx_write(8'h22);
            wait_tx_ready("tx_ready_after_second_load");
         end
      join
      idle_checks("after_b2b");

      // Empty buffer, abort after 5 bits
      master_frame(1'b0, 1'b0, 16'h5500, 5, 1'b1);
      check("abort_fill_prefix", {27'h0, rd_acc[4:0]}, 32'h1F);
      idle_checks("after_abort");
      check("abort_tx_ready", {31'h0, tx_ready}, 32'h1);

      // Reset at bit 4 with cs held low
      master_frame(1'b0, 1'b0, 16'hAA00, 4, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      idle_checks("midreset");
      check("midreset_rx_data", {24'h0, rx_data}, 32'h0);
      check("midreset_tx_ready", {31'h0, tx_ready}, 32'h1);
      reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         sck  = ~sck;
         mosi = ~mosi;
         #(HALF);
      end
      idle_checks("cs_low_after_reset");
      cs   = 1'b1;
      mosi = 1'b0;
      #(4 * HALF);
      single(1'b0, 1'b0, 8'h06, 8'h08);

      for (int n = 0; n < 200 && (exp_rx_q.size() != 0 || exp_miso_q.size() != 0); n++)
         @(negedge clk);
      check("rx_queue_drained", 32'(exp_rx_q.size()), 32'h0);
      check("miso_queue_drained", 32'(exp_miso_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
